// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data RTC bus master with timed strobe phases.
// Define RTC_BUS_BURST_EN to enable multi-beat bursts with address increment.
module rtc_bus_ctrl #(
  parameter int DATA_W  = 8,
  parameter int T_ADS   = 2,
  parameter int T_ACC   = 3,
  parameter int T_ADT   = 1,
  parameter int T_W     = 2,
  parameter int BURST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              AD,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              busy,
  output logic              done,
  output logic              beat_done,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = 8;

  // Counter reload values are length-1; a zero length behaves as one clock.
  localparam logic [CNT_W-1:0] L_ADS =
    CNT_W'((T_ADS < 1) ? 0 : T_ADS - 1);
  localparam logic [CNT_W-1:0] L_ACC =
    CNT_W'((T_ACC < 1) ? 0 : T_ACC - 1);
  localparam logic [CNT_W-1:0] L_ADT =
    CNT_W'((T_ADT < 1) ? 0 : T_ADT - 1);
  localparam logic [CNT_W-1:0] L_W =
    CNT_W'((T_W < 1) ? 0 : T_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADS, S_AACC, S_ADT,
    S_TW, S_DACC, S_DREC, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              beat_done_q, beat_done_d;
  logic              last;

`ifdef RTC_BUS_BURST_EN
  logic [BURST_W-1:0] beats_q, beats_d;
`else
  logic unused_burst;
  assign unused_burst = ^burst_len;
`endif

  assign last = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    beat_done_d = 1'b0;
`ifdef RTC_BUS_BURST_EN
    beats_d     = beats_q;
`endif
    if (!last) cnt_d = cnt_q - 1'b1;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ADS;
        cnt_d   = L_ADS;
        addr_d  = addr;
        rw_d    = rw;
`ifdef RTC_BUS_BURST_EN
        beats_d = burst_len;
`endif
      end
      S_ADS: if (last) begin
        state_d = S_AACC;
        cnt_d   = L_ACC;
      end
      S_AACC: if (last) begin
        state_d = S_ADT;
        cnt_d   = L_ADT;
      end
      S_ADT: if (last) begin
        state_d = S_TW;
        cnt_d   = L_W;
        wdata_d = wdata;
      end
      S_TW: if (last) begin
        state_d = S_DACC;
        cnt_d   = L_ACC;
      end
      S_DACC: if (last) begin
        if (!rw_q) rdata_d = ad_in;
        state_d     = S_DREC;
        cnt_d       = L_W;
        beat_done_d = 1'b1;
      end
      S_DREC: if (last) begin
        state_d = S_DONE;
        cnt_d   = '0;
`ifdef RTC_BUS_BURST_EN
        if (beats_q != '0) begin
          state_d = S_ADS;
          cnt_d   = L_ADS;
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      beat_done_q <= 1'b0;
`ifdef RTC_BUS_BURST_EN
      beats_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      beat_done_q <= beat_done_d;
`ifdef RTC_BUS_BURST_EN
      beats_q     <= beats_d;
`endif
    end
  end

  // Bus pins decode straight from state so reset releases them at once.
  always_comb begin
    AD     = 1'b1;
    CS     = 1'b1;
    RD     = 1'b1;
    WR     = 1'b1;
    ad_oe  = 1'b0;
    ad_out = '0;
    unique case (state_q)
      S_ADS: begin
        AD     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_AACC: begin
        AD     = 1'b0;
        CS     = 1'b0;
        WR     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_ADT: begin
        AD     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_TW: begin
        ad_oe  = rw_q;
        ad_out = rw_q ? wdata_q : '0;
      end
      S_DACC: begin
        CS     = 1'b0;
        RD     = rw_q;
        WR     = !rw_q;
        ad_oe  = rw_q;
        ad_out = rw_q ? wdata_q : '0;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign beat_done = beat_done_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed self-checking bench for rtc_bus_ctrl.
// Covers default timing, write, burst, reset abort, busy start and T_ACC=0.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, start2, rw;
  logic [7:0] addr, wdata, ad_in;
  logic [3:0] burst_len;

  logic [7:0] ad_out, rdata;
  logic       ad_oe, ad_n, cs_n, rd_n, wr_n, busy, done, beat_done;
  logic [7:0] ad_out0, rdata0;
  logic       ad_oe0, ad0_n, cs0_n, rd0_n, wr0_n, busy0, done0, beat0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_bus_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .addr(addr), .burst_len(burst_len), .wdata(wdata),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .AD(ad_n), .CS(cs_n), .RD(rd_n), .WR(wr_n),
    .busy(busy), .done(done), .beat_done(beat_done),
    .rdata(rdata)
  );

  rtc_bus_ctrl #(.T_ACC(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start2), .rw(rw),
    .addr(addr), .burst_len(burst_len), .wdata(wdata),
    .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0),
    .AD(ad0_n), .CS(cs0_n), .RD(rd0_n), .WR(wr0_n),
    .busy(busy0), .done(done0), .beat_done(beat0),
    .rdata(rdata0)
  );

  // Per-transaction observation, sampled on the falling edge.
  logic       sel = 1'b0;
  int         n, done_at, done_cnt, beat_cnt;
  int         cs_runs, cs_run, cs_max, cs_tot;
  int         wr_low, wr_low_ad1, rd_low, ad_runs;
  int         both_low = 0;
  int         oe_viol = 0;
  logic       cs_prev, oe_prev, ad_prev;
  logic [7:0] addrs [8];

  always @(negedge clk) begin
    logic m_ad, m_cs, m_rd, m_wr, m_oe, m_done, m_beat;
    logic [7:0] m_out;
    m_ad   = sel ? ad0_n : ad_n;
    m_cs   = sel ? cs0_n : cs_n;
    m_rd   = sel ? rd0_n : rd_n;
    m_wr   = sel ? wr0_n : wr_n;
    m_oe   = sel ? ad_oe0 : ad_oe;
    m_done = sel ? done0 : done;
    m_beat = sel ? beat0 : beat_done;
    m_out  = sel ? ad_out0 : ad_out;
    if (!m_rd && !m_wr) both_low++;
    if (!m_cs && !cs_prev && m_oe != oe_prev) oe_viol++;
    if (!m_cs) begin
      cs_tot++;
      cs_run++;
      if (cs_run > cs_max) cs_max = cs_run;
      if (cs_prev) cs_runs++;
    end else begin
      cs_run = 0;
    end
    if (!m_wr) begin
      wr_low++;
      if (m_ad) wr_low_ad1++;
    end
    if (!m_rd) rd_low++;
    if (m_done) begin
      done_cnt++;
      if (done_at < 0) done_at = n;
    end
    if (m_beat) beat_cnt++;
    if (!m_ad && ad_prev) begin
      if (ad_runs < 8) addrs[ad_runs] = m_out;
      ad_runs++;
    end
    cs_prev = m_cs;
    oe_prev = m_oe;
    ad_prev = m_ad;
    n++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    n = 0; done_at = -1; done_cnt = 0; beat_cnt = 0;
    cs_runs = 0; cs_run = 0; cs_max = 0; cs_tot = 0;
    wr_low = 0; wr_low_ad1 = 0; rd_low = 0; ad_runs = 0;
    cs_prev = 1'b1; oe_prev = 1'b0; ad_prev = 1'b1;
    for (int i = 0; i < 8; i++) addrs[i] = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; start2 = 1'b0; rw = 1'b0;
    addr = 8'h00; wdata = 8'h00; ad_in = 8'h00; burst_len = 4'd0;
    clear_mon();
    #2;
    total++;
    if ({ad_n, cs_n, rd_n, wr_n, ad_oe, busy, done, beat_done}
        !== 8'b1111_0000) begin
      bad++;
      $display("FAIL reset_pins got=%b want=11110000",
        {ad_n, cs_n, rd_n, wr_n, ad_oe, busy, done, beat_done});
    end
    total++;
    if (ad_out !== 8'h00 || rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_data ad_out=%h rdata=%h want 00",
        ad_out, rdata);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read;
    rw = 1'b0; addr = 8'h25; ad_in = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    clear_mon();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL read_busy got=%b want=1", busy);
    end
    repeat (16) tick();
    total++;
    if (done_at !== 13 || done_cnt !== 1) begin
      bad++;
      $display("FAIL read_done at=%0d cnt=%0d want 13/1",
        done_at, done_cnt);
    end
    total++;
    if (cs_runs !== 2 || cs_max !== 3 || cs_tot !== 6) begin
      bad++;
      $display("FAIL read_cs runs=%0d max=%0d tot=%0d want 2/3/6",
        cs_runs, cs_max, cs_tot);
    end
    total++;
    if (wr_low !== 3 || wr_low_ad1 !== 0 || rd_low !== 3) begin
      bad++;
      $display("FAIL read_strobes wr=%0d wr_ad1=%0d rd=%0d want 3/0/3",
        wr_low, wr_low_ad1, rd_low);
    end
    total++;
    if (rdata !== 8'h5A || addrs[0] !== 8'h25 || beat_cnt !== 1) begin
      bad++;
      $display("FAIL read_data rdata=%h addr=%h beats=%0d want 5a/25/1",
        rdata, addrs[0], beat_cnt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL read_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_write;
    rw = 1'b1; addr = 8'h0E; wdata = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    clear_mon();
    total++;
    if (ad_n !== 1'b0 || ad_oe !== 1'b1 || ad_out !== 8'h0E) begin
      bad++;
      $display("FAIL wr_addr AD=%b oe=%b out=%h want 0/1/0e",
        ad_n, ad_oe, ad_out);
    end
    repeat (6) tick();
    total++;
    if (ad_n !== 1'b1 || ad_oe !== 1'b1 || ad_out !== 8'hC3) begin
      bad++;
      $display("FAIL wr_data AD=%b oe=%b out=%h want 1/1/c3",
        ad_n, ad_oe, ad_out);
    end
    wdata = 8'h00;
    repeat (2) tick();
    total++;
    if (ad_out !== 8'hC3 || wr_n !== 1'b0 || cs_n !== 1'b0) begin
      bad++;
      $display("FAIL wr_latch out=%h WR=%b CS=%b want c3/0/0",
        ad_out, wr_n, cs_n);
    end
    repeat (8) tick();
    total++;
    if (wr_low !== 6 || rd_low !== 0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL wr_strobes wr=%0d rd=%0d done=%0d want 6/0/1",
        wr_low, rd_low, done_cnt);
    end
  endtask

  task automatic test_burst;
    int exp_beats;
    int exp_done;
    rw = 1'b0; addr = 8'hFE; burst_len = 4'd2; start = 1'b1;
`ifdef RTC_BUS_BURST_EN
    exp_beats = 3;
`else
    exp_beats = 1;
`endif
    exp_done = 13 * exp_beats;
    tick();
    start = 1'b0;
    burst_len = 4'd0;
    clear_mon();
    repeat (45) tick();
    total++;
    if (beat_cnt !== exp_beats || ad_runs !== exp_beats) begin
      bad++;
      $display("FAIL burst_beats beats=%0d addr_ph=%0d want %0d",
        beat_cnt, ad_runs, exp_beats);
    end
    total++;
    if (done_cnt !== 1 || done_at !== exp_done) begin
      bad++;
      $display("FAIL burst_done cnt=%0d at=%0d want 1/%0d",
        done_cnt, done_at, exp_done);
    end
    total++;
    if (addrs[0] !== 8'hFE) begin
      bad++; $display("FAIL burst_a0 got=%h want=fe", addrs[0]);
    end
`ifdef RTC_BUS_BURST_EN
    total++;
    if (addrs[1] !== 8'hFF || addrs[2] !== 8'h00) begin
      bad++;
      $display("FAIL burst_wrap a1=%h a2=%h want ff/00",
        addrs[1], addrs[2]);
    end
`endif
  endtask

  task automatic test_reset_mid;
    rw = 1'b1; addr = 8'h40; wdata = 8'h99; start = 1'b1;
    tick();
    start = 1'b0;
    clear_mon();
    repeat (8) tick();
    total++;
    if (cs_n !== 1'b0 || wr_n !== 1'b0 || ad_oe !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre CS=%b WR=%b oe=%b want 0/0/1",
        cs_n, wr_n, ad_oe);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({ad_n, cs_n, rd_n, wr_n, ad_oe, busy, done, beat_done}
        !== 8'b1111_0000) begin
      bad++;
      $display("FAIL rst_mid got=%b want=11110000",
        {ad_n, cs_n, rd_n, wr_n, ad_oe, busy, done, beat_done});
    end
    total++;
    if (ad_out !== 8'h00 || rdata !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_data out=%h rdata=%h want 00",
        ad_out, rdata);
    end
    tick();
    reset = 1'b1;
    rw = 1'b0; addr = 8'h33; ad_in = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    clear_mon();
    repeat (16) tick();
    total++;
    if (done_at !== 13 || rdata !== 8'h77 || addrs[0] !== 8'h33) begin
      bad++;
      $display("FAIL rst_after at=%0d rdata=%h addr=%h want 13/77/33",
        done_at, rdata, addrs[0]);
    end
  endtask

  task automatic test_busy_start;
    rw = 1'b0; addr = 8'h31; ad_in = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    clear_mon();
    repeat (4) tick();
    addr = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    total++;
    if (done_cnt !== 1 || ad_runs !== 1 || addrs[0] !== 8'h31) begin
      bad++;
      $display("FAIL busy_start done=%0d txns=%0d addr=%h want 1/1/31",
        done_cnt, ad_runs, addrs[0]);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_start_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_tacc0;
    sel = 1'b1;
    rw = 1'b0; addr = 8'h10; ad_in = 8'hA6; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    clear_mon();
    repeat (12) tick();
    total++;
    if (cs_runs !== 2 || cs_max !== 1 || cs_tot !== 2) begin
      bad++;
      $display("FAIL tacc0_cs runs=%0d max=%0d tot=%0d want 2/1/2",
        cs_runs, cs_max, cs_tot);
    end
    total++;
    if (done_at !== 9 || rdata0 !== 8'hA6) begin
      bad++;
      $display("FAIL tacc0_done at=%0d rdata=%h want 9/a6",
        done_at, rdata0);
    end
    sel = 1'b0;
  endtask

  task automatic test_safety;
    total++;
    if (both_low !== 0 || oe_viol !== 0) begin
      bad++;
      $display("FAIL safety rdwr_low=%0d oe_chg=%0d want 0/0",
        both_low, oe_viol);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_burst();
    test_reset_mid();
    test_busy_start();
    test_tacc0();
    test_safety();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 8, multiplexed address/data width in bits.
REQ-002 SHALL have parameter T_ADS, 2, address-setup phase length in clocks.
REQ-003 SHALL have parameter T_ACC, 3, strobe (CS low) phase length in clocks.
REQ-004 SHALL have parameter T_ADT, 1, address-hold phase length in clocks.
REQ-005 SHALL have parameter T_W, 2, turnaround/recovery phase length in clocks.
REQ-006 SHALL have parameter BURST_W, 4, burst-length field width.
REQ-007 SHALL have port clk, input, 1, the only clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, transaction request, sampled only in IDLE.
REQ-010 SHALL have port rw, input, 1, 0=read, 1=write, captured with start.
REQ-011 SHALL have port addr, input, DATA_W, first register address, captured with start.
REQ-012 SHALL have port burst_len, input, BURST_W, beats minus one, captured with start.
REQ-013 SHALL have port wdata, input, DATA_W, write data, sampled on entry to TW each beat.
REQ-014 SHALL have port ad_in, input, DATA_W, bus data from the device.
REQ-015 SHALL have ports ad_out (output, DATA_W) and ad_oe (output, 1), bus drive value and enable.
REQ-016 SHALL have ports AD, CS, RD, WR, output, 1 each, active-low bus strobes (AD low = address phase).
REQ-017 SHALL have ports busy, done, beat_done, output, 1 each; rdata, output, DATA_W.

Function
REQ-018 SHALL implement states IDLE, ADS, AACC, ADT, TW, DACC, DREC, DONE; each timed phase lasts exactly its parameter count (0 treated as 1) via one shared down-counter.
REQ-019 SHALL leave IDLE for ADS on the edge sampling start=1; start while busy=1 ignored.
REQ-020 SHALL sequence ADS(T_ADS) -> AACC(T_ACC) -> ADT(T_ADT) -> TW(T_W) -> DACC(T_ACC) -> DREC(T_W).
REQ-021 SHALL drive: IDLE AD/CS/RD/WR=1, ad_oe=0; ADS AD=0, ad_oe=1, ad_out=address; AACC AD=0, CS=0, WR=0, address driven; ADT AD=0, CS/WR=1, address driven.
REQ-022 SHALL drive: TW AD=1, strobes high, ad_oe=rw; DACC CS=0 plus RD=0 (read) or WR=0 (write), ad_oe=rw, ad_out=wdata latched at TW entry; DREC strobes high, ad_oe=0; DONE as IDLE.
REQ-023 SHALL load rdata from ad_in on the last DACC clock of a read beat; rdata held otherwise.
REQ-024 SHALL pulse beat_done one clock on DREC entry each beat.
REQ-025 SHALL, at DREC end, return to ADS with address+1 (modulo 2^DATA_W, wrap 0xFF->0x00 at DATA_W=8) if beats remain, else enter DONE.
REQ-026 SHALL assert done for exactly the one DONE clock, then return to IDLE; busy=1 in every state except IDLE.
REQ-027 SHALL never assert RD and WR low simultaneously, nor CS low while ad_oe changes value.

Reset
REQ-028 SHALL on reset=0 immediately force state IDLE, AD/CS/RD/WR=1, ad_oe=0, ad_out=0, busy/done/beat_done=0, rdata=0, counters 0, including mid-transaction; no resumption after release.
REQ-029 SHALL accept start on the first clock edge after reset deasserts.

Configuration
REQ-030 SHALL, with RTC_BUS_BURST_EN defined, perform burst_len+1 beats per REQ-025.
REQ-031 SHALL, without RTC_BUS_BURST_EN, ignore burst_len, perform exactly one beat, and omit the beat counter and address incrementer.

Verification
REQ-032 SHALL cover defaults, read addr=0x25, ad_in=0x5A -> CS low twice (3 clocks each), done high 13 clocks after the start edge for one clock, rdata=0x5A, WR low only in AACC.
REQ-033 SHALL cover write addr=0x0E, wdata=0xC3 -> ad_out=0x0E with AD=0 then 0xC3 with AD=1, WR low in AACC and DACC, RD never low.
REQ-034 SHALL cover burst read addr=0xFE, burst_len=2 (BURST_EN) -> addresses 0xFE, 0xFF, 0x00, three beat_done pulses, one done.
REQ-035 SHALL cover reset=0 asserted during DACC of a write -> same-cycle strobes high, ad_oe=0, busy=0; new start after release completes normally.
REQ-036 SHALL cover start pulsed while busy -> ignored, transaction count unchanged.
REQ-037 SHALL cover T_ACC=0 instance -> strobe phases last 1 clock.
